// File: rtl/board_ctrl_if.sv
// Button/frame inputs and display-state outputs of the tic-tac-toe board controller.
// The master drives buttons and vblnk; the slave (board_ctrl) publishes the display state.
interface board_ctrl_if;
    logic        vblnk;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_sel;
    logic        btn_restart;
    logic [17:0] cell_state;
    logic [3:0]  cursor;
    logic [1:0]  turn;
    logic        game_over;
    logic [1:0]  winner;
    logic [8:0]  win_line;
    logic        move_err;

    modport master (
        output vblnk, btn_up, btn_down, btn_left, btn_right, btn_sel, btn_restart,
        input  cell_state, cursor, turn, game_over, winner, win_line, move_err
    );

    modport slave (
        input  vblnk, btn_up, btn_down, btn_left, btn_right, btn_sel, btn_restart,
        output cell_state, cursor, turn, game_over, winner, win_line, move_err
    );
endinterface

// File: rtl/board_ctrl.sv
// Game-state controller for the 3x3 grid: board, cursor, turn, win/draw detection,
// with display state shadowed on the rising edge of vblnk so a frame never tears.
module board_ctrl #(
    parameter int CURSOR_INIT         = 4,
    parameter int FIRST_PLAYER        = 1,
    parameter int MOVE_TIMEOUT_FRAMES = 600
) (
    input logic         clk,
    input logic         rst,
    board_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_PLAY, S_CHECK, S_OVER} state_t;

    localparam logic [3:0] CUR_INIT = 4'(CURSOR_INIT);
    localparam logic [1:0] P_INIT   = 2'(FIRST_PLAYER);
    localparam logic [9:0] TO_LAST  = 10'(MOVE_TIMEOUT_FRAMES - 1);
    localparam bit         TO_EN    = (MOVE_TIMEOUT_FRAMES != 0);

    state_t      state, state_n;
    logic [17:0] board, board_n;
    logic [3:0]  cur, cur_n, col;
    logic [1:0]  turn_r, turn_n;
    logic [9:0]  timer, timer_n;
    logic [1:0]  winner_r, winner_n;
    logic [8:0]  line_r, line_n;
    logic        err_n;
    logic        vblnk_d, fe;
    logic [8:0]  mine, full, hits;

    function automatic logic [8:0] line_mask(input int k);
        case (k)
            0:       line_mask = 9'b000_000_111;
            1:       line_mask = 9'b000_111_000;
            2:       line_mask = 9'b111_000_000;
            3:       line_mask = 9'b001_001_001;
            4:       line_mask = 9'b010_010_010;
            5:       line_mask = 9'b100_100_100;
            6:       line_mask = 9'b100_010_001;
            default: line_mask = 9'b001_010_100;
        endcase
    endfunction

    function automatic logic [1:0] other(input logic [1:0] p);
        other = (p == 2'b01) ? 2'b10 : 2'b01;
    endfunction

    assign fe  = bus.vblnk & ~vblnk_d;
    assign col = cur % 4'd3;

    // Lines completed by the player to move; used only in CHECK, after the placement.
    always_comb begin
        mine = '0;
        full = '0;
        hits = '0;
        for (int i = 0; i < 9; i++) begin
            mine[i] = (board[2*i +: 2] == turn_r);
            full[i] = (board[2*i +: 2] != 2'b00);
        end
        for (int k = 0; k < 8; k++) begin
            if ((mine & line_mask(k)) == line_mask(k))
                hits = hits | line_mask(k);
        end
    end

    always_comb begin
        state_n  = state;
        board_n  = board;
        cur_n    = cur;
        turn_n   = turn_r;
        timer_n  = timer;
        winner_n = winner_r;
        line_n   = line_r;
        err_n    = 1'b0;
        if (bus.btn_restart) begin
            state_n  = S_PLAY;
            board_n  = '0;
            cur_n    = CUR_INIT;
            turn_n   = P_INIT;
            timer_n  = '0;
            winner_n = '0;
            line_n   = '0;
        end else begin
            case (state)
                S_PLAY: begin
                    if (TO_EN && fe) begin
                        if (timer == TO_LAST) begin
                            timer_n = '0;
                            turn_n  = other(turn_r);
                        end else begin
                            timer_n = timer + 10'd1;
                        end
                    end
                    // An accepted sel overrides a forfeit landing on the same cycle.
                    if (bus.btn_sel) begin
                        if (board[{cur, 1'b0} +: 2] == 2'b00) begin
                            board_n[{cur, 1'b0} +: 2] = turn_r;
                            turn_n  = turn_r;
                            timer_n = '0;
                            state_n = S_CHECK;
                        end else begin
                            err_n = 1'b1;
                        end
                    end else if (bus.btn_up) begin
                        cur_n = (cur < 4'd3) ? cur + 4'd6 : cur - 4'd3;
                    end else if (bus.btn_down) begin
                        cur_n = (cur > 4'd5) ? cur - 4'd6 : cur + 4'd3;
                    end else if (bus.btn_left) begin
                        cur_n = (col == 4'd0) ? cur + 4'd2 : cur - 4'd1;
                    end else if (bus.btn_right) begin
                        cur_n = (col == 4'd2) ? cur - 4'd2 : cur + 4'd1;
                    end
                end
                S_CHECK: begin
                    if (hits != 9'd0) begin
                        state_n  = S_OVER;
                        winner_n = turn_r;
                        line_n   = hits;
                    end else if (&full) begin
                        state_n  = S_OVER;
                        winner_n = 2'b11;
                    end else begin
                        state_n = S_PLAY;
                        turn_n  = other(turn_r);
                    end
                end
                S_OVER: begin
                    err_n = bus.btn_sel | bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
                end
                default: state_n = S_PLAY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_PLAY;
            board          <= '0;
            cur            <= CUR_INIT;
            turn_r         <= P_INIT;
            timer          <= '0;
            winner_r       <= '0;
            line_r         <= '0;
            vblnk_d        <= 1'b0;
            bus.move_err   <= 1'b0;
            bus.cell_state <= '0;
            bus.cursor     <= CUR_INIT;
            bus.turn       <= P_INIT;
            bus.game_over  <= 1'b0;
            bus.winner     <= '0;
            bus.win_line   <= '0;
        end else begin
            state        <= state_n;
            board        <= board_n;
            cur          <= cur_n;
            turn_r       <= turn_n;
            timer        <= timer_n;
            winner_r     <= winner_n;
            line_r       <= line_n;
            vblnk_d      <= bus.vblnk;
            bus.move_err <= err_n;
            // Display copies take the pre-update state, so a result lands one frame later.
            if (fe) begin
                bus.cell_state <= board;
                bus.cursor     <= cur;
                bus.turn       <= turn_r;
                bus.game_over  <= (state == S_OVER);
                bus.winner     <= winner_r;
                bus.win_line   <= line_r;
            end
        end
    end
endmodule
